// File: rtl/frame_pkg.sv
// Shared frame geometry and arbiter FSM encoding for the frame RAM path.
// Latency: n/a (constants, types and one elaboration-time helper only).
// Backpressure: n/a.
package frame_pkg;

    // 320x240 frame of 8-bit pixels stored linearly in one single-port RAM.
    localparam int FRAME_W     = 320;
    localparam int FRAME_H     = 240;
    localparam int FRAME_DEPTH = FRAME_W * FRAME_H;
    localparam int FRAME_AW    = 17;
    localparam int PIX_W       = 8;

    // Arbiter control states. SWITCH is the single bubble between owners.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_SWITCH = 2'd2
    } arb_state_e;

    // Index width for an n-entry selector; never collapses to zero bits.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_ram_arbiter_rr_pick.sv
// Round-robin priority selector: first set request at or after the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is taken.
//
// Ports:
//   req_i  [N-1:0]  request vector
//   ptr_i  [PW-1:0] index with the highest priority this cycle (must be < N)
//   win_o  [N-1:0]  one-hot winner, all zero when nothing requests
//   vld_o           a winner exists
module rr_pick
    import frame_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic          vld_o
);

    logic [PW-1:0] idx;

    // Walk the ring starting at the pointer; the first hit wins and later
    // hits are masked by vld_o.
    always_comb begin
        win_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!vld_o && req_i[idx]) begin
                win_o[idx] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Round-robin, burst-locked arbiter sharing one single-port frame RAM among N_REQ engines.
// Latency: grant 1 cycle after request from idle (2 after an owner drops); read data RD_LAT cycles after the access.
// Backpressure: requesters wait with req_i high until gnt_o; read responses cannot be stalled.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   req_i/we_i [N_REQ]        per-requester request and write flag
//   addr_i [N_REQ*AW]         packed addresses, requester k at [k*AW +: AW]
//   data_i [N_REQ*DW]         packed write data, requester k at [k*DW +: DW]
//   gnt_o [N_REQ]             registered one-hot grant
//   rvalid_o [N_REQ], data_o  tagged read response on a shared data bus
//   addr_err_o [N_REQ]        pulse in an access cycle whose address is >= DEPTH
//   ram_en_o/ram_we_o/ram_addr_o/ram_data_o/ram_data_i  direct RAM port
// Optional: define FRAME_ARB_STATS_EN to add grant_cnt_o [N_REQ*32], one
//   saturating access counter per requester (error accesses included).
module frame_ram_arbiter
    import frame_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int AW        = FRAME_AW,
    parameter int DW        = PIX_W,
    parameter int DEPTH     = FRAME_DEPTH,
    parameter int MAX_BURST = 64,
    parameter int RD_LAT    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    we_i,
    input  logic [N_REQ*AW-1:0] addr_i,
    input  logic [N_REQ*DW-1:0] data_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    rvalid_o,
    output logic [DW-1:0]       data_o,
    output logic [N_REQ-1:0]    addr_err_o,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [AW-1:0]       ram_addr_o,
    output logic [DW-1:0]       ram_data_o,
    input  logic [DW-1:0]       ram_data_i
`ifdef FRAME_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0] grant_cnt_o
`endif
);

    localparam int PW = ptr_w(N_REQ);
    localparam int BW = ptr_w(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0]   DEPTH_V    = (AW + 1)'(DEPTH);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [BW-1:0]    burst_q, burst_d;

    // Read return pipeline: valid, requester tag and address-error flag.
    logic [RD_LAT-1:0]         rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0][PW-1:0] rd_tag_q, rd_tag_d;
    logic [RD_LAT-1:0]         rd_err_q, rd_err_d;
    logic [DW-1:0]             data_q,   data_d;

    // ---------------------------------------------------------------
    // Granted-requester datapath
    // ---------------------------------------------------------------
    logic [PW-1:0]    gidx;
    logic             acc;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             addr_bad;
    logic             others_pend;
    logic [PW-1:0]    ptr_next;
    logic [N_REQ-1:0] pick_win;
    logic             pick_vld;

    always_comb begin
        gidx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_q[k]) gidx = PW'(k);
        end
    end

    // An access happens in every GRANT cycle where the owner still requests;
    // the owner may drop req_i at any time without penalty.
    assign acc         = (state_q == ARB_GRANT) && |(gnt_q & req_i);
    assign sel_we      = we_i[gidx];
    assign sel_addr    = addr_i[int'(gidx)*AW +: AW];
    assign sel_data    = data_i[int'(gidx)*DW +: DW];
    assign addr_bad    = {1'b0, sel_addr} >= DEPTH_V;
    assign others_pend = |(req_i & ~gnt_q);
    assign ptr_next    = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .vld_o (pick_vld)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        case (state_q)
            // SWITCH already carries the bubble, so it arbitrates exactly
            // like IDLE; that keeps the handover to one dead cycle.
            ARB_IDLE, ARB_SWITCH: begin
                gnt_d = '0;
                if (pick_vld) begin
                    gnt_d   = pick_win;
                    burst_d = '0;
                    state_d = ARB_GRANT;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!acc) begin
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = ARB_SWITCH;
                end else if (burst_q == BURST_LAST) begin
                    burst_d = '0;
                    // Burst limit only forces a handover when someone waits;
                    // a lone streamer keeps the RAM with a fresh count.
                    if (others_pend) begin
                        gnt_d   = '0;
                        ptr_d   = ptr_next;
                        state_d = ARB_SWITCH;
                    end
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (RAM port driven straight from the granted inputs)
    // ---------------------------------------------------------------
    always_comb begin
        gnt_o      = gnt_q;
        ram_en_o   = acc && !addr_bad;
        ram_we_o   = acc && !addr_bad && sel_we;
        ram_addr_o = acc ? sel_addr : '0;
        ram_data_o = acc ? sel_data : '0;
        addr_err_o = (acc && addr_bad) ? gnt_q : '0;
    end

    // ---------------------------------------------------------------
    // Read return path
    // ---------------------------------------------------------------
    // The tag travels with the read so responses land on the right
    // requester even after the grant has moved on. Out-of-range reads
    // still occupy a slot and come back as zero.
    always_comb begin
        rd_vld_d    = '0;
        rd_tag_d    = '0;
        rd_err_d    = '0;
        rd_vld_d[0] = acc && !sel_we;
        rd_tag_d[0] = gidx;
        rd_err_d[0] = addr_bad;
        for (int s = 1; s < RD_LAT; s++) begin
            rd_vld_d[s] = rd_vld_q[s-1];
            rd_tag_d[s] = rd_tag_q[s-1];
            rd_err_d[s] = rd_err_q[s-1];
        end
    end

    always_comb begin
        rvalid_o = '0;
        data_o   = data_q;
        if (rd_vld_q[RD_LAT-1]) begin
            rvalid_o[rd_tag_q[RD_LAT-1]] = 1'b1;
            data_o = rd_err_q[RD_LAT-1] ? '0 : ram_data_i;
        end
        // Bus holds the last returned value between responses.
        data_d = data_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_vld_q <= '0;
            rd_tag_q <= '0;
            rd_err_q <= '0;
            data_q   <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_tag_q <= rd_tag_d;
            rd_err_q <= rd_err_d;
            data_q   <= data_d;
        end
    end

`ifdef FRAME_ARB_STATS_EN
    // ---------------------------------------------------------------
    // Per-requester access counters, saturating at all-ones
    // ---------------------------------------------------------------
    logic [N_REQ-1:0][31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (acc && gnt_q[k] && (cnt_q[k] != 32'hFFFF_FFFF)) begin
                cnt_d[k] = cnt_q[k] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule
